// File: rtl/barrett_mult_arbiter.sv
// ---------------------------------------------------------------------------
// barrett_mult_arbiter
//
// Shares one external, fixed-latency, non-stallable Barrett multiplier among
// N_REQ requesters. A round-robin arbiter issues at most one operation per
// cycle. A requester id travels in a tag pipeline beside the multiplier, and
// that id steers each product back to the requester that asked for it.
//
// Handshake: a requester raises req_valid[i] with its operands. The
// operation is accepted on the rising edge where req_valid[i] & req_ready[i].
// req_ready depends combinationally on req_valid, so a requester must not
// derive valid from ready. Responses cannot be back-pressured: rsp_valid[i]
// is high for exactly one cycle, and requester i must capture rsp_data then.
//
// Ports
//   clk, reset_n       rising-edge clock, asynchronous active-low reset
//   enable             0 blocks new issue; in-flight operations still return
//   req_valid/num1/2   per-requester request and operands
//   req_ready          one-hot grant
//   mult_num1/2        registered operands driven to the multiplier
//   mult_product       multiplier result, MULT_LATENCY cycles after operands
//   rsp_valid/rsp_data one-hot response strobe and result data
//   in_flight          accepted operations whose result has not yet returned
//   idle               nothing in flight and no request pending
// ---------------------------------------------------------------------------
module barrett_mult_arbiter #(
    parameter int N_BITS       = 254,
    parameter int N_REQ        = 3,
    parameter int MULT_LATENCY = 12
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [N_REQ-1:0][N_BITS-1:0]   req_num1,
    input  logic [N_REQ-1:0][N_BITS-1:0]   req_num2,
    output logic [N_REQ-1:0]               req_ready,
    output logic [N_BITS-1:0]              mult_num1,
    output logic [N_BITS-1:0]              mult_num2,
    input  logic [N_BITS-1:0]              mult_product,
    output logic [N_REQ-1:0]               rsp_valid,
    output logic [N_BITS-1:0]              rsp_data,
    output logic [4:0]                     in_flight,
    output logic                           idle
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LAT   = MULT_LATENCY;

    logic [PTR_W-1:0]          rr_ptr;
    logic [PTR_W-1:0]          grant_id;
    logic [PTR_W-1:0]          next_ptr;
    logic [PTR_W:0]            cand;
    logic                      accept;

    // Slot 0 is loaded on the accept edge, together with mult_num1/2.
    // After LAT more shifts, the tag reaches slot LAT. This happens in the
    // same cycle as the matching product on mult_product.
    logic [LAT:0]              tag_vld;
    logic [LAT:0][PTR_W-1:0]   tag_id;

    // Round-robin search from rr_ptr upward with wraparound. The loop runs
    // from the farthest offset down, so the nearest valid requester is
    // assigned last and wins.
    always_comb begin
        req_ready = '0;
        grant_id  = '0;
        accept    = 1'b0;
        cand      = '0;
        if (enable && reset_n) begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
                if (cand >= (PTR_W+1)'(N_REQ)) begin
                    cand = cand - (PTR_W+1)'(N_REQ);
                end
                if (req_valid[cand[PTR_W-1:0]]) begin
                    accept   = 1'b1;
                    grant_id = cand[PTR_W-1:0];
                end
            end
        end
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign next_ptr = (grant_id == PTR_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mult_num1 <= '0;
            mult_num2 <= '0;
            tag_vld   <= '0;
            tag_id    <= '0;
            rr_ptr    <= '0;
            in_flight <= '0;
        end else begin
            // The multiplier cannot stall, so the tag line shifts every cycle.
            tag_vld <= {tag_vld[LAT-1:0], accept};
            tag_id  <= {tag_id[LAT-1:0], grant_id};
            if (accept) begin
                mult_num1 <= req_num1[grant_id];
                mult_num2 <= req_num2[grant_id];
                rr_ptr    <= next_ptr;
            end
            // An accept and a response in the same cycle cancel out.
            in_flight <= in_flight + 5'(accept) - 5'(tag_vld[LAT]);
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (tag_vld[LAT]) begin
            rsp_valid[tag_id[LAT]] = 1'b1;
        end
    end

    assign rsp_data = mult_product;
    assign idle     = (in_flight == 5'd0) && !(|req_valid);

endmodule

// File: tb/tb_barrett_mult_arbiter.sv
// ---------------------------------------------------------------------------
// tb_barrett_mult_arbiter
//
// Self-checking bench for barrett_mult_arbiter. A behavioural 12-stage
// modular multiplier over the BN254 scalar field stands in for the external
// Barrett unit. The reference model keeps a round-robin pointer and a queue
// of expected responses. Each queue entry holds a due cycle, a requester id
// and a product. The product is computed straight from the operands the
// bench drove.
// ---------------------------------------------------------------------------
module tb_barrett_mult_arbiter;

    localparam int N_BITS = 254;
    localparam int N_REQ  = 3;
    localparam int LAT    = 12;
    localparam logic [N_BITS-1:0] PRIME =
        254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    // ---------------- clock / reset / DUT ----------------
    logic                          clk;
    logic                          reset_n;
    logic                          enable;
    logic [N_REQ-1:0]              req_valid;
    logic [N_REQ-1:0][N_BITS-1:0]  req_num1;
    logic [N_REQ-1:0][N_BITS-1:0]  req_num2;
    logic [N_REQ-1:0]              req_ready;
    logic [N_BITS-1:0]             mult_num1;
    logic [N_BITS-1:0]             mult_num2;
    logic [N_BITS-1:0]             mult_product;
    logic [N_REQ-1:0]              rsp_valid;
    logic [N_BITS-1:0]             rsp_data;
    logic [4:0]                    in_flight;
    logic                          idle;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    barrett_mult_arbiter #(
        .N_BITS(N_BITS), .N_REQ(N_REQ), .MULT_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .req_valid(req_valid), .req_num1(req_num1), .req_num2(req_num2),
        .req_ready(req_ready), .mult_num1(mult_num1), .mult_num2(mult_num2),
        .mult_product(mult_product), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .in_flight(in_flight), .idle(idle)
    );

    // ---------------- field arithmetic ----------------
    function automatic logic [N_BITS-1:0] mod_mul(input logic [N_BITS-1:0] a,
                                                  input logic [N_BITS-1:0] b);
        logic [2*N_BITS-1:0] wa, wb, wp, pr;
        wa = {{N_BITS{1'b0}}, a};
        wb = {{N_BITS{1'b0}}, b};
        wp = {{N_BITS{1'b0}}, PRIME};
        pr = (wa * wb) % wp;
        return pr[N_BITS-1:0];
    endfunction

    function automatic logic [N_BITS-1:0] rand_fe();
        logic [255:0] r;
        logic [255:0] m;
        r = '0;
        for (int w = 0; w < 8; w++) r = {r[223:0], 32'($urandom())};
        m = r % {2'b00, PRIME};
        return m[N_BITS-1:0];
    endfunction

    // Stand-in multiplier: the product appears LAT cycles after the operands
    // are registered at its inputs.
    logic [N_BITS-1:0] mp [LAT];
    assign mult_product = mp[LAT-1];
    always @(posedge clk) begin
        mp[0] <= mod_mul(mult_num1, mult_num2);
        for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end

    // ---------------- scoreboard ----------------
    int                 n_tests;
    int                 n_fail;
    int                 cyc;
    int                 model_rr;
    int                 exp_due[$];
    int                 exp_id[$];
    logic [N_BITS-1:0]  exp_q[$];

    task automatic check(input string tag, input logic [N_BITS-1:0] got,
                         input logic [N_BITS-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Round robin: first valid requester at or after rr, wrapping around.
    function automatic int model_grant(input int rr, input logic [N_REQ-1:0] v,
                                       input logic en, input logic rn);
        if (!en || !rn) return -1;
        for (int k = 0; k < N_REQ; k++) begin
            if (v[(rr + k) % N_REQ]) return (rr + k) % N_REQ;
        end
        return -1;
    endfunction

    // One clock cycle: check outputs mid-cycle, update the model, then
    // advance past the rising edge.
    task automatic tick();
        logic [N_REQ-1:0]  e_ready;
        logic [N_REQ-1:0]  e_rsp;
        int                g;
        bit                due;
        @(negedge clk);
        if (!reset_n) begin
            exp_due.delete();
            exp_id.delete();
            exp_q.delete();
            model_rr = 0;
        end
        g       = model_grant(model_rr, req_valid, enable, reset_n);
        e_ready = (g >= 0) ? (N_REQ'(1) << g) : '0;
        due     = (exp_due.size() > 0) && (exp_due[0] == cyc);
        e_rsp   = due ? (N_REQ'(1) << exp_id[0]) : '0;
        check("req_ready", N_BITS'(req_ready), N_BITS'(e_ready));
        check("rsp_valid", N_BITS'(rsp_valid), N_BITS'(e_rsp));
        if (due) check("rsp_data", rsp_data, exp_q[0]);
        check("in_flight", N_BITS'(in_flight), N_BITS'(exp_due.size()));
        check("idle", N_BITS'(idle),
              N_BITS'((exp_due.size() == 0) && (req_valid == '0)));
        if (due) begin
            void'(exp_due.pop_front());
            void'(exp_id.pop_front());
            void'(exp_q.pop_front());
        end
        if (g >= 0) begin
            exp_due.push_back(cyc + LAT + 1);
            exp_id.push_back(g);
            exp_q.push_back(mod_mul(req_num1[g], req_num2[g]));
            model_rr = (g + 1) % N_REQ;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic rand_operands();
        for (int i = 0; i < N_REQ; i++) begin
            req_num1[i] = rand_fe();
            req_num2[i] = rand_fe();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        model_rr  = 0;
        reset_n   = 1'b0;
        enable    = 1'b1;
        req_valid = '0;
        req_num1  = '0;
        req_num2  = '0;

        // reset
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // single operation: 2 x 3
        req_num1[0] = N_BITS'(2);
        req_num2[0] = N_BITS'(3);
        req_valid   = 3'b001;
        tick();
        req_valid = '0;
        repeat (15) tick();

        // contention: all requesters valid, operands (i+1)*10 x 1
        for (int i = 0; i < N_REQ; i++) begin
            req_num1[i] = N_BITS'((i + 1) * 10);
            req_num2[i] = N_BITS'(1);
        end
        req_valid = 3'b111;
        repeat (9) tick();
        req_valid = '0;
        repeat (15) tick();

        // fairness after the pointer moves past the last requester
        req_valid = 3'b010;
        tick();
        req_valid = 3'b011;
        repeat (2) tick();
        req_valid = '0;
        repeat (14) tick();

        // field wraparound: (p-1)^2 = 1, 0 * x = 0
        req_num1[0] = PRIME - N_BITS'(1);
        req_num2[0] = PRIME - N_BITS'(1);
        req_valid   = 3'b001;
        tick();
        req_num1[0] = '0;
        tick();
        req_valid = '0;
        repeat (14) tick();

        // randomized traffic with occasional enable drops
        repeat (400) begin
            req_valid = N_REQ'($urandom_range(0, 7));
            enable    = ($urandom_range(0, 7) != 0);
            rand_operands();
            tick();
        end
        enable    = 1'b1;
        req_valid = '0;
        repeat (15) tick();

        // reset while five operations are in flight
        req_valid = 3'b111;
        repeat (5) begin
            rand_operands();
            tick();
        end
        req_valid = '0;
        repeat (3) tick();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n   = 1'b1;
        req_valid = 3'b111;
        repeat (3) begin
            rand_operands();
            tick();
        end
        req_valid = '0;
        repeat (20) tick();

        // enable gating: blocked issue, then drop enable after three accepts
        enable    = 1'b0;
        req_valid = 3'b111;
        repeat (5) tick();
        enable = 1'b1;
        repeat (3) begin
            rand_operands();
            tick();
        end
        enable = 1'b0;
        repeat (16) tick();
        req_valid = '0;
        enable    = 1'b1;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
